// File: rtl/branch_resolve_unit_if.sv
// ID-stage branch resolution bus: operands and branch controls from the
// decode stage, with stall/flush/redirect status back from the resolve unit.
interface branch_resolve_unit_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       branch_select;
    logic             branch;
    logic             jump;
    logic             operands_valid;
    logic             stall;
    logic             flush;
    logic [15:0]      redirect_count;

    modport master (
        output a, b, branch_select, branch, jump, operands_valid,
        input  stall, flush, redirect_count
    );

    modport slave (
        input  a, b, branch_select, branch, jump, operands_valid,
        output stall, flush, redirect_count
    );
endinterface

// File: rtl/branch_resolve_unit.sv
// Resolves branches/jumps in ID: compares forwarded operands, stalls on
// unresolved operands and raises a registered multi-cycle flush on redirect.
module branch_resolve_unit #(
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 1,
    parameter int SIGNED       = 1
) (
    input  logic clk,
    input  logic rst,
    branch_resolve_unit_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_OPS = 2'b01,
        FLUSH    = 2'b10
    } state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t           state_r;
    logic [3:0]       count_r;
    logic             flush_r;
    logic [15:0]      redirect_count_r;

    logic [WIDTH-1:0] a_s;
    logic [WIDTH-1:0] b_s;
    logic             lt_s;
    logic             gt_s;
    logic             eq_s;
    logic             cond_s;
    logic             go_flush_s;

    assign a_s = bus.a;
    assign b_s = bus.b;

    // Magnitude compare with parameter-selected signedness.
    always_comb begin
        lt_s = 1'b0;
        gt_s = 1'b0;
        if (SIGNED != 0) begin
            lt_s = $signed(a_s) < $signed(b_s);
            gt_s = $signed(a_s) > $signed(b_s);
        end else begin
            lt_s = a_s < b_s;
            gt_s = a_s > b_s;
        end
        eq_s = (a_s == b_s);
    end

    // Branch condition selected by the branch_select code.
    always_comb begin
        cond_s = 1'b0;
        case (bus.branch_select)
            3'b000:  cond_s = lt_s;
            3'b001:  cond_s = gt_s;
            3'b010:  cond_s = eq_s;
            3'b011:  cond_s = ~eq_s;
            3'b100:  cond_s = ~gt_s;
            3'b101:  cond_s = ~lt_s;
            default: cond_s = 1'b0;
        endcase
    end

    // Redirect decision; jump wins over branch and ignores operands_valid.
    always_comb begin
        go_flush_s = 1'b0;
        case (state_r)
            IDLE:     go_flush_s = bus.jump | (bus.branch & bus.operands_valid & cond_s);
            WAIT_OPS: go_flush_s = bus.operands_valid & cond_s;
            default:  go_flush_s = 1'b0;
        endcase
    end

    // Resolution FSM with flush down-counter and saturating redirect counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r          <= IDLE;
            count_r          <= 4'd0;
            flush_r          <= 1'b0;
            redirect_count_r <= 16'd0;
        end else begin
            if (go_flush_s && (redirect_count_r != 16'hFFFF)) begin
                redirect_count_r <= redirect_count_r + 16'd1;
            end
            case (state_r)
                IDLE: begin
                    if (go_flush_s) begin
                        state_r <= FLUSH;
                        count_r <= FLUSH_LOAD;
                        flush_r <= 1'b1;
                    end else if (bus.branch && !bus.operands_valid) begin
                        state_r <= WAIT_OPS;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT_OPS: begin
                    if (go_flush_s) begin
                        state_r <= FLUSH;
                        count_r <= FLUSH_LOAD;
                        flush_r <= 1'b1;
                    end else if (bus.operands_valid) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= WAIT_OPS;
                    end
                end
                FLUSH: begin
                    // Instructions seen here are being squashed, so branch/jump are ignored.
                    if (count_r == 4'd0) begin
                        state_r <= IDLE;
                        flush_r <= 1'b0;
                    end else begin
                        count_r <= count_r - 4'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    flush_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.stall = ~rst & (((state_r == IDLE) & bus.branch & ~bus.jump & ~bus.operands_valid)
                             | ((state_r == WAIT_OPS) & ~bus.operands_valid));
    assign bus.flush          = flush_r;
    assign bus.redirect_count = redirect_count_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench: three configurations share one stimulus stream and are
// checked every cycle against a cycle-indexed behavioural reference.
module tb_branch_resolve_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    branch_resolve_unit_if #(.WIDTH(16)) if0 ();
    branch_resolve_unit_if #(.WIDTH(16)) if1 ();
    branch_resolve_unit_if #(.WIDTH(16)) if2 ();

    branch_resolve_unit #(.WIDTH(16), .FLUSH_CYCLES(1), .SIGNED(1)) u_d0 (.clk(clk), .rst(rst), .bus(if0));
    branch_resolve_unit #(.WIDTH(16), .FLUSH_CYCLES(1), .SIGNED(0)) u_d1 (.clk(clk), .rst(rst), .bus(if1));
    branch_resolve_unit #(.WIDTH(16), .FLUSH_CYCLES(3), .SIGNED(1)) u_d2 (.clk(clk), .rst(rst), .bus(if2));

    typedef struct {
        int          dut;
        int          cyc;
        logic        stall;
        logic        flush;
        logic [15:0] count;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          failures = 0;
    int          cycle = 0;
    int          fc[3] = '{1, 1, 3};
    bit          sg[3] = '{1'b1, 1'b0, 1'b1};
    int          flush_until[3] = '{0, 0, 0};
    logic [15:0] mcount[3] = '{16'd0, 16'd0, 16'd0};

    logic [2:0]  act_stall;
    logic [2:0]  act_flush;
    logic [15:0] act_count[3];
    assign act_stall = {if2.stall, if1.stall, if0.stall};
    assign act_flush = {if2.flush, if1.flush, if0.flush};
    assign act_count[0] = if0.redirect_count;
    assign act_count[1] = if1.redirect_count;
    assign act_count[2] = if2.redirect_count;

    // last-applied inputs, used to keep a waiting branch held
    logic        h_br = 1'b0, h_j = 1'b0, h_v = 1'b1, h_r = 1'b1;
    logic [2:0]  h_s = 3'd0;

    function automatic bit cond_ref(bit sgn, logic [2:0] s, logic [15:0] x, logic [15:0] y);
        int sx, sy;
        sx = sgn ? int'($signed(x)) : int'(x);
        sy = sgn ? int'($signed(y)) : int'(y);
        case (s)
            3'd0:    return sx <  sy;
            3'd1:    return sx >  sy;
            3'd2:    return sx == sy;
            3'd3:    return sx != sy;
            3'd4:    return sx <= sy;
            3'd5:    return sx >= sy;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic r, j, br, v, input logic [2:0] s, input logic [15:0] aa, bb);
        rst = r;
        if0.jump = j; if1.jump = j; if2.jump = j;
        if0.branch = br; if1.branch = br; if2.branch = br;
        if0.operands_valid = v; if1.operands_valid = v; if2.operands_valid = v;
        if0.branch_select = s; if1.branch_select = s; if2.branch_select = s;
        if0.a = aa; if1.a = aa; if2.a = aa;
        if0.b = bb; if1.b = bb; if2.b = bb;
        h_r = r; h_j = j; h_br = br; h_v = v; h_s = s;
    endtask

    // Expected outputs for this cycle, then the redirect this cycle causes.
    task automatic model(input logic r, j, br, v, input logic [2:0] s, input logic [15:0] aa, bb);
        exp_t e;
        bit in_fl;
        for (int k = 0; k < 3; k++) begin
            e.dut = k;
            e.cyc = cycle;
            if (r) begin
                e.stall = 1'b0; e.flush = 1'b0; e.count = 16'd0;
                flush_until[k] = 0;
                mcount[k] = 16'd0;
            end else begin
                in_fl   = cycle < flush_until[k];
                e.flush = in_fl;
                e.stall = !in_fl && br && !j && !v;
                e.count = mcount[k];
                if (!in_fl && (j || (br && v && cond_ref(sg[k], s, aa, bb)))) begin
                    flush_until[k] = cycle + 1 + fc[k];
                    if (mcount[k] != 16'hFFFF) mcount[k] = mcount[k] + 16'd1;
                end
            end
            sbq.push_back(e);
        end
    endtask

    task automatic step(input logic r, j, br, v, input logic [2:0] s, input logic [15:0] aa, bb);
        @(posedge clk);
        #1;
        drive(r, j, br, v, s, aa, bb);
        model(r, j, br, v, s, aa, bb);
        cycle++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
    endtask

    function automatic logic [15:0] pick_operand();
        case ($urandom_range(0, 6))
            0:       return 16'h0000;
            1:       return 16'h0001;
            2:       return 16'hFFFF;
            3:       return 16'h8000;
            4:       return 16'h7FFF;
            5:       return 16'(2);
            default: return 16'($urandom);
        endcase
    endfunction

    // Monitor: pop every pending expectation and compare against the DUT it names.
    always @(negedge clk) begin
        exp_t e;
        while (sbq.size() > 0) begin
            e = sbq.pop_front();
            checks += 3;
            if (act_stall[e.dut] !== e.stall) begin
                failures++;
                $display("FAIL stall dut%0d cyc%0d: got %b expected %b", e.dut, e.cyc, act_stall[e.dut], e.stall);
            end
            if (act_flush[e.dut] !== e.flush) begin
                failures++;
                $display("FAIL flush dut%0d cyc%0d: got %b expected %b", e.dut, e.cyc, act_flush[e.dut], e.flush);
            end
            if (act_count[e.dut] !== e.count) begin
                failures++;
                $display("FAIL redirect_count dut%0d cyc%0d: got %h expected %h", e.dut, e.cyc, act_count[e.dut], e.count);
            end
        end
    end

    initial begin
        logic [15:0] ra, rb;
        logic        rj, rbr, rv;
        logic [2:0]  rs;
        logic [15:0] pa[3] = '{16'd1, 16'd1, 16'd0};
        logic [15:0] pb[3] = '{16'd0, 16'd1, 16'd1};

        drive(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        idle(2);

        // BLT -1 < 1: taken when signed, not when unsigned
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 16'hFFFF, 16'd1);
        idle(4);

        // every select code against (1,0), (1,1), (0,1)
        for (int s = 0; s < 8; s++) begin
            for (int p = 0; p < 3; p++) begin
                step(1'b0, 1'b0, 1'b1, 1'b1, 3'(s), pa[p], pb[p]);
                idle(4);
            end
        end

        // load-use BEQ: three stalled cycles then resolution
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 3'd2, 16'd5, 16'd5);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'd5, 16'd5);
        idle(4);

        // jump with unresolved branch, then a taken BEQ during the flush
        step(1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 16'd3, 16'd4);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'd2, 16'd2);
        step(1'b0, 1'b0, 1'b1, 1'b1, 3'd2, 16'd2, 16'd2);
        idle(5);

        // reset on the second cycle of a 3-cycle flush
        step(1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        idle(1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        idle(3);

        // reset while waiting for operands
        step(1'b0, 1'b0, 1'b1, 1'b0, 3'd3, 16'd1, 16'd2);
        step(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        idle(2);

        // randomized traffic; a stalled branch is held until its operands arrive
        for (int i = 0; i < 400; i++) begin
            ra = pick_operand();
            rb = ($urandom_range(0, 3) == 0) ? ra : pick_operand();
            if (!h_r && h_br && !h_j && !h_v) begin
                rj = 1'b0; rbr = 1'b1; rs = h_s;
                rv = ($urandom_range(0, 2) == 0);
            end else begin
                rj  = ($urandom_range(0, 7) == 0);
                rbr = $urandom_range(0, 1) != 0;
                rv  = ($urandom_range(0, 3) != 0);
                rs  = 3'($urandom_range(0, 7));
            end
            step(1'b0, rj, rbr, rv, rs, ra, rb);
        end
        if (h_br && !h_j && !h_v) step(1'b0, 1'b0, 1'b1, 1'b1, h_s, 16'd0, 16'd0);
        idle(4);

        // saturation: preload near the top, then back-to-back jumps
        @(posedge clk);
        #1;
        force u_d0.redirect_count_r = 16'hFFF0;
        force u_d1.redirect_count_r = 16'hFFF0;
        force u_d2.redirect_count_r = 16'hFFF0;
        for (int k = 0; k < 3; k++) mcount[k] = 16'hFFF0;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        model(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 16'd0);
        cycle++;
        #1;
        release u_d0.redirect_count_r;
        release u_d1.redirect_count_r;
        release u_d2.redirect_count_r;
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0, 16'd0);
        idle(4);

        @(negedge clk);
        #1;
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sbq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Parametrised branch/jump resolution unit for the ID stage of the 5-stage pipeline. It compares two forwarded operands under a selectable condition, stalls while the operands are not yet valid, and drives a registered, multi-cycle flush when a branch is taken or a jump occurs. It also keeps a saturating count of redirects for performance monitoring.

## Interface
Parameters:
- WIDTH, 16, operand width in bits.
- FLUSH_CYCLES, 1, cycles `flush` stays high per redirect (1..15).
- SIGNED, 1, 1 = signed compare for lt/gt/le/ge, 0 = unsigned.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  WIDTH  first compare operand (forwarded).
- b  input  WIDTH  second compare operand (forwarded).
- branch_select  input  3  000 BLT, 001 BGT, 010 BEQ, 011 BNE, 100 BLE, 101 BGE, 11x never taken.
- branch  input  1  instruction in ID is a conditional branch.
- jump  input  1  instruction in ID is an unconditional jump; has priority over `branch`.
- operands_valid  input  1  `a`/`b` hold final values (no pending load-use).
- stall  output  1  hold IF/ID; combinational.
- flush  output  1  squash younger instructions; registered.
- redirect_count  output  16  saturating count of taken branches plus jumps.

## Operation
- Condition `cond`, combinational on a, b, branch_select: lt, gt, eq, ne, le, ge per select code. Signedness follows SIGNED. Codes 110/111 give cond = 0.
- FSM states:
  - IDLE
    - `jump` → FLUSH.
    - `branch & operands_valid & cond` → FLUSH.
    - `branch & operands_valid & !cond` → stay IDLE.
    - `branch & !operands_valid & !jump` → WAIT_OPS.
  - WAIT_OPS
    - `operands_valid & cond` → FLUSH.
    - `operands_valid & !cond` → IDLE.
    - otherwise stay. branch_select, a and b are re-evaluated every cycle; the pipeline holds the instruction while stalled.
  - FLUSH: a 4-bit down-counter is loaded with FLUSH_CYCLES-1 on entry. Go to IDLE when it reaches 0. `branch`/`jump` are ignored in FLUSH because those instructions are being squashed.
- stall = (IDLE & branch & !jump & !operands_valid) | (WAIT_OPS & !operands_valid). stall is never high in FLUSH.
- flush = 1 exactly while the state is FLUSH (Moore output).
- redirect_count increments by 1 on every transition into FLUSH and holds at 16'hFFFF once reached.

## Timing
- Reset values: state IDLE, flush 0, counter 0, redirect_count 0. Asserting rst mid-FLUSH or mid-WAIT_OPS drops flush to 0 immediately and returns to IDLE. stall is 0 while rst is high.
- Resolution at rising edge k → flush is high for cycles k+1 .. k+FLUSH_CYCLES and low at k+FLUSH_CYCLES+1. redirect_count updates at edge k.
- Zero-wait branch (operands_valid high): 1-cycle resolution latency, no stall.
- Load-use branch: stall is high in the same cycle as `branch & !operands_valid` and stays high until the cycle in which operands_valid rises. That cycle resolves with stall = 0.
- A new branch or jump presented on the cycle after FLUSH exits is evaluated normally. There is no dead cycle.
- Simultaneous `jump` and `branch`: treated as a jump; operands_valid is ignored.

## Test plan
- WIDTH=16, SIGNED=1, FLUSH_CYCLES=1. Apply BLT with a=16'hFFFF (−1), b=1, operands_valid=1 → flush high for exactly one cycle, redirect_count=1. Repeat with SIGNED=0 → no flush, count unchanged.
- Sweep every select code with pairs (1,0), (1,1), (0,1). For each pair check flush:
  - BLT: 0,0,1
  - BGT: 1,0,0
  - BEQ: 0,1,0
  - BNE: 1,0,1
  - BLE: 0,1,1
  - BGE: 1,1,0
  - 110 and 111: 0,0,0
- Load-use BEQ: a=b=5, operands_valid low for 3 cycles → stall high for those 3 cycles, flush 0. Raise operands_valid → stall 0 that cycle, flush high on the next cycle.
- FLUSH_CYCLES=3, jump=1 with branch=1 and operands_valid=0 → no stall, flush high for exactly 3 cycles. A taken BEQ presented during the flush → ignored, count +1 only.
- Assert rst on the second cycle of a 3-cycle flush → flush 0 immediately. After release, flush 0, stall 0, redirect_count 0.
- Force 65536 jumps (FLUSH_CYCLES=1) → redirect_count saturates at 16'hFFFF and does not wrap to 0.
